// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: the CPU, DMA and memory-side signals of the shared data-memory port.
// Ports: slave = arbiter view (requests in, memory pins out); master = requesters and memory.
interface dmem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data memory between the MEM stage and a DMA requester.
// Ports: clock, resetn (sync, active low), bus (slave modport: cpu_*, dma_*, mem_*).
module dmem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              resetn,
  dmem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);

  typedef enum logic {
    S_OPEN,
    S_ACK
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_nxt;
  logic          dma_elig;
  logic          dma_grant;
  logic          cpu_grant;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= S_OPEN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = '0;
    // resetn gates every grant so nothing reaches memory during reset
    dma_elig  = resetn & bus.dma_req & (state == S_OPEN);
    dma_grant = dma_elig & (~bus.cpu_req | (wait_cnt == WMAX));
    cpu_grant = resetn & bus.cpu_req & ~dma_grant;
    unique case (state)
      S_OPEN: if (dma_grant) state_nxt = S_ACK;
      S_ACK:  state_nxt = S_OPEN;
    endcase
    // a held request keeps ageing, also in the ack cycle
    if (bus.dma_req && !dma_grant) begin
      if (wait_cnt == WMAX) wait_nxt = wait_cnt;
      else                  wait_nxt = wait_cnt + 1'b1;
    end
  end

  assign addr_mux  = dma_grant ? bus.dma_addr  : bus.cpu_addr;
  assign wdata_mux = dma_grant ? bus.dma_wdata : bus.cpu_wdata;

  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.mem_we    = dma_grant ? bus.dma_we
                                   : (cpu_grant & bus.cpu_we);

  assign bus.cpu_stall = bus.cpu_req & dma_grant;
  assign bus.dma_ack   = resetn & (state == S_ACK);
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dma_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and random checks of the data-memory port arbiter.
// Ports: none; drives the interface and models a synchronous memory behind it.
module tb_dmem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  dmem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_WAIT(MW)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  // memory: registered read, old data on same-cycle write
  logic [31:0] mem [256] = '{default: 32'h0};
  always @(posedge clock) begin
    if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[7:0]];
  end

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] ref_mem [256] = '{default: 32'h0};
  bit          m_known = 0;
  bit          m_ack   = 0;
  int          m_wait  = 0;
  bit          m_crd   = 0;
  bit          m_drd   = 0;
  logic [31:0] m_cexp;
  logic [31:0] m_dexp;

  logic        o_we, o_stall, o_ack;
  logic [31:0] o_addr, o_crd, o_drd;
  int          o_wait;
  bit          dma_done;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic cr, cw, dr, dw, rn, gd, gc;
    logic [31:0] ca, cd, da, dd;
    @(negedge clock);
    rn = resetn;
    cr = bus.cpu_req; cw = bus.cpu_we;
    ca = bus.cpu_addr; cd = bus.cpu_wdata;
    dr = bus.dma_req; dw = bus.dma_we;
    da = bus.dma_addr; dd = bus.dma_wdata;
    // DMA wins when free of a pending ack and the CPU is idle or it has waited long enough
    gd = rn && dr && !m_ack && (!cr || m_wait >= MW);
    gc = rn && cr && !gd;
    o_we = bus.mem_we; o_stall = bus.cpu_stall; o_ack = bus.dma_ack;
    o_addr = bus.mem_addr; o_crd = bus.cpu_rdata; o_drd = bus.dma_rdata;
    o_wait = int'(dut.wait_cnt);
    chk("mem_we", 32'(o_we), 32'(gd ? dw : (gc && cw)));
    chk("cpu_stall", 32'(o_stall), 32'(cr && gd));
    chk("dma_ack", 32'(o_ack), 32'(rn && m_ack));
    if (m_known) chk("wait_cnt", 32'(o_wait), 32'(m_wait));
    if (gd) chk("mem_addr_dma", o_addr, da);
    if (gc) chk("mem_addr_cpu", o_addr, ca);
    if (gd && dw) chk("mem_wdata_dma", bus.mem_wdata, dd);
    if (gc && cw) chk("mem_wdata_cpu", bus.mem_wdata, cd);
    if (rn && m_crd) chk("cpu_rdata", o_crd, m_cexp);
    if (rn && m_ack && m_drd) chk("dma_rdata", o_drd, m_dexp);
    @(posedge clock);
    if (!rn) begin
      m_known = 1; m_ack = 0; m_wait = 0; m_crd = 0; m_drd = 0;
    end else begin
      m_crd  = gc && !cw;
      m_cexp = ref_mem[ca[7:0]];
      m_drd  = gd && !dw;
      m_dexp = ref_mem[da[7:0]];
      if (gd && dw) ref_mem[da[7:0]] = dd;
      if (gc && cw) ref_mem[ca[7:0]] = cd;
      if (gd || !dr) m_wait = 0;
      else           m_wait = (m_wait + 1 > MW) ? MW : m_wait + 1;
      m_ack = gd;
    end
    #1;
  endtask

  task automatic set_cpu(input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    bus.cpu_req = r; bus.cpu_we = w;
    bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_dma(input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    bus.dma_req = r; bus.dma_we = w;
    bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  initial begin
    set_cpu(1, 1, 32'h4, 32'h11);
    set_dma(1, 1, 32'h8, 32'h22);
    resetn = 0;
    // 1: reset with both requesters writing
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t1_mem_we", 32'(o_we), 32'h0);
      chk("t1_stall", 32'(o_stall), 32'h0);
      chk("t1_ack", 32'(o_ack), 32'h0);
    end
    resetn = 1;
    set_dma(0, 0, 0, 0);
    set_cpu(0, 0, 0, 0);
    cycle();
    // 2: CPU only
    set_cpu(1, 1, 32'h10, 32'hDEADBEEF);
    cycle();
    chk("t2_we", 32'(o_we), 32'h1);
    chk("t2_stall_w", 32'(o_stall), 32'h0);
    set_cpu(1, 0, 32'h10, 32'h0);
    cycle();
    chk("t2_stall_r", 32'(o_stall), 32'h0);
    set_cpu(0, 0, 32'h0, 32'h0);
    cycle();
    chk("t2_rdata", o_crd, 32'hDEADBEEF);
    // 3: DMA only
    set_dma(1, 1, 32'h20, 32'h1234);
    cycle();
    chk("t3_wgrant_we", 32'(o_we), 32'h1);
    chk("t3_wgrant_ack", 32'(o_ack), 32'h0);
    cycle();
    chk("t3_wack", 32'(o_ack), 32'h1);
    set_dma(1, 0, 32'h20, 32'h0);
    cycle();
    chk("t3_rgrant_ack", 32'(o_ack), 32'h0);
    chk("t3_rgrant_addr", o_addr, 32'h20);
    cycle();
    chk("t3_rack", 32'(o_ack), 32'h1);
    chk("t3_rdata", o_drd, 32'h1234);
    set_dma(0, 0, 0, 0);
    cycle();
    chk("t3_idle_ack", 32'(o_ack), 32'h0);
    // 4: starvation limit under continuous CPU traffic
    for (int k = 0; k < 6; k++) begin
      set_cpu(1, 0, 32'(k), 32'h0);
      set_dma(1, 1, 32'h30, 32'hA5A5);
      cycle();
      chk("t4_stall", 32'(o_stall), 32'(k == 4));
      chk("t4_ack", 32'(o_ack), 32'(k == 5));
      if (k == 5) chk("t4_wait", 32'(o_wait), 32'h0);
    end
    set_dma(0, 0, 0, 0);
    set_cpu(0, 0, 0, 0);
    cycle();
    // 5: DMA alone gets the port at once
    set_dma(1, 0, 32'h30, 32'h0);
    cycle();
    chk("t5_stall", 32'(o_stall), 32'h0);
    chk("t5_addr", o_addr, 32'h30);
    cycle();
    chk("t5_ack", 32'(o_ack), 32'h1);
    chk("t5_rdata", o_drd, 32'hA5A5);
    set_dma(0, 0, 0, 0);
    cycle();
    // 6: reset lands on the forced grant
    for (int k = 0; k < 11; k++) begin
      resetn = (k != 4);
      set_cpu(1, 0, 32'h40, 32'h0);
      set_dma(1, 1, 32'h44, 32'h77);
      cycle();
      chk("t6_stall", 32'(o_stall), 32'(k == 9));
      chk("t6_ack", 32'(o_ack), 32'(k == 10));
      if (k == 5) chk("t6_wait", 32'(o_wait), 32'h0);
    end
    resetn = 1;
    set_dma(0, 0, 0, 0);
    set_cpu(0, 0, 0, 0);
    cycle();
    // random traffic; the DMA holds each request until it sees its ack
    dma_done = 0;
    for (int i = 0; i < 600; i++) begin
      resetn = ($urandom_range(0, 59) != 0);
      set_cpu($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              32'($urandom_range(0, 63)), $urandom);
      if (!bus.dma_req || dma_done)
        set_dma($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                32'($urandom_range(0, 63)), $urandom);
      cycle();
      dma_done = o_ack;
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
